gshare_branch_predictor: RTL
============================

Name: gshare_branch_predictor

Overview:
- Parametrised successor to the 8-bit global-history predictor in the sail-core fetch/decode path.
- Indexes a 2^HIST_BITS table of CTR_BITS-wide saturating counters with the speculative global history, optionally XOR-hashed with PC bits.
- Tracks up to INFLIGHT_DEPTH unresolved branches and repairs history on a misprediction.
- Self-initialises the table after reset using a sweep FSM; no simulation-only initial blocks.

Parameters:
- HIST_BITS, 8: history length; table depth is 2^HIST_BITS.
- CTR_BITS, 2: counter width, at least 2.
- PC_LSB, 2: lowest PC bit used in the hash.
- INFLIGHT_DEPTH, 2: number of outstanding branch slots, at least 1.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst_n, input, 1: synchronous, active-low reset.
- branch_decode_sig, input, 1: decode stage holds a conditional branch.
- pc_branch_addr, input, 32: PC of the decoding branch.
- offset, input, 32: branch immediate.
- branch_mem_sig, input, 1: the oldest in-flight branch resolves this cycle.
- actual_branch_decision, input, 1: resolved direction, 1 = taken.
- out_branch_addr, output, 32: pc_branch_addr + offset, combinational, modulo 2^32.
- prediction, output, 1: predicted taken, combinational.
- mispredict, output, 1: resolving branch was mispredicted, combinational.
- init_done, output, 1: table sweep complete.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - state <= INIT, sweep pointer <= 0, spec_ghr <= 0, FIFO emptied, init_done <= 0.
  - prediction and mispredict read 0 while init_done = 0.
- INIT state:
  - Each cycle: table[ptr] <= WEAK = 1 << (CTR_BITS-1), ptr <= ptr + 1.
  - Decode and resolve inputs are ignored.
  - After entry 2^HIST_BITS-1 is written, state becomes RUN and init_done = 1. That is the 2^HIST_BITS-th posedge with rst_n = 1.
  - rst_n low mid-sweep restarts the sweep at 0.
- Index: idx = spec_ghr (see GSHARE_XOR_EN).
- prediction = init_done & branch_decode_sig & table[idx][CTR_BITS-1].
- Decode push, taken when RUN & branch_decode_sig & FIFO not full & no mispredict this cycle:
  - Push {idx, prediction, ckpt = spec_ghr}.
  - spec_ghr <= {spec_ghr[HIST_BITS-2:0], prediction}.
- FIFO full on decode: prediction is forced to 0, nothing is pushed, and spec_ghr is unchanged.
- Resolve, taken when RUN & branch_mem_sig & FIFO not empty:
  - Pop the head entry.
  - table[head.idx] saturates toward actual_branch_decision: +1 capped at all-ones, or -1 floored at 0.
  - mispredict = (head.pred != actual_branch_decision).
- Resolve with the FIFO empty: ignored, no table write, mispredict = 0.
- On mispredict:
  - spec_ghr <= {head.ckpt[HIST_BITS-2:0], actual_branch_decision}.
  - All younger FIFO entries are flushed.
  - A decode in the same cycle is dropped; its prediction is still shown but is not tracked.
- Correct resolve with a decode in the same cycle: pop and push both occur, so the count is unchanged.
- Same-cycle read and write of the same entry: prediction uses the pre-update counter (read-before-write).
- Counter arithmetic is CTR_BITS wide; the saturation check prevents any wrap.
- FIFO pointers wrap modulo INFLIGHT_DEPTH.
- The count register is wide enough to hold INFLIGHT_DEPTH.

Optional Feature:
- Macro GSHARE_XOR_EN.
- Defined: idx = spec_ghr ^ pc_branch_addr[PC_LSB+HIST_BITS-1:PC_LSB] (gshare).
- Undefined: idx = spec_ghr only (pure global-history predictor). The PC is used only for out_branch_addr.

Test Plan:
- Reset then sweep: hold rst_n = 0 for 2 cycles, then release. Require init_done = 0 for 255 posedges and 1 after the 256th. A decode at idx 0 then gives prediction = 1 (counter 2'b10).
- Saturation: 3 branches at the same idx resolve taken. Counter goes 2→3→3 with prediction 1. Then 4 not-taken resolves take it 3→2→1→0→0 with prediction 0 from counter 1 onward.
- Mispredict repair:
  - Set spec_ghr = 8'h5A.
  - Decode A (pred 1, spec_ghr becomes 8'hB5), then decode B (spec_ghr 8'h6A or 8'h6B).
  - Resolve A not-taken: mispredict = 1, B is flushed, spec_ghr = 8'hB4.
- FIFO full (INFLIGHT_DEPTH = 2): 3 decodes with no resolve. The 3rd has prediction 0 and spec_ghr shifts only twice.
- Resolve with empty FIFO while branch_mem_sig = 1: no table change and mispredict = 0. Same-cycle correct resolve and decode: count stays 1.
- Reset mid-sweep (at ptr = 100): sweep restarts at 0, with init_done at 256 cycles after the new release. Without GSHARE_XOR_EN, PCs 0x100 and 0x204 with equal history hit the same entry.

Source files
------------

// File: rtl/gshare_branch_predictor_if.sv
// Purpose: fetch/decode-side bundle for the gshare predictor (decode, resolve, results).
// Latency: pure wiring; prediction, mispredict and target are combinational in the predictor.
// Backpressure: none on the bus; a full in-flight queue forces a not-taken, untracked prediction.
interface gshare_branch_predictor_if;
    logic        branch_decode_sig;
    logic [31:0] pc_branch_addr;
    logic [31:0] offset;
    logic        branch_mem_sig;
    logic        actual_branch_decision;
    logic [31:0] out_branch_addr;
    logic        prediction;
    logic        mispredict;
    logic        init_done;

    // Pipeline side: drives decode/resolve, observes predictor results.
    modport master (
        output branch_decode_sig, pc_branch_addr, offset, branch_mem_sig, actual_branch_decision,
        input  out_branch_addr, prediction, mispredict, init_done
    );

    // Predictor side.
    modport slave (
        input  branch_decode_sig, pc_branch_addr, offset, branch_mem_sig, actual_branch_decision,
        output out_branch_addr, prediction, mispredict, init_done
    );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Purpose: global-history (optionally PC-hashed when GSHARE_XOR_EN is defined) branch predictor with in-flight repair.
// Latency: prediction/mispredict/target combinational; table, history and queue update on the next posedge.
// Backpressure: when INFLIGHT_DEPTH branches are unresolved, a new decode predicts not-taken and is not tracked.
module gshare_branch_predictor #(
    parameter int HIST_BITS      = 8,
    parameter int CTR_BITS       = 2,
    parameter int PC_LSB         = 2,
    parameter int INFLIGHT_DEPTH = 2
) (
    input logic                      clk,
    input logic                      rst_n,
    gshare_branch_predictor_if.slave bus
);
    localparam int TBL_DEPTH = 1 << HIST_BITS;
    localparam int PTR_W     = (INFLIGHT_DEPTH > 1) ? $clog2(INFLIGHT_DEPTH) : 1;
    localparam int CNT_W     = $clog2(INFLIGHT_DEPTH + 1);
    localparam logic [CTR_BITS-1:0] WEAK    = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                 state;
    logic [HIST_BITS-1:0]   sweep_ptr;
    logic                   init_done_q;
    logic [HIST_BITS-1:0]   spec_ghr;
    logic [CTR_BITS-1:0]    ctr_table [TBL_DEPTH];

    // In-flight branch queue: table index, predicted direction, history checkpoint.
    logic [HIST_BITS-1:0]   fifo_idx  [INFLIGHT_DEPTH];
    logic                   fifo_pred [INFLIGHT_DEPTH];
    logic [HIST_BITS-1:0]   fifo_ckpt [INFLIGHT_DEPTH];
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [CNT_W-1:0]       count;

    logic [HIST_BITS-1:0]   idx;
    logic                   run;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pred;
    logic                   resolve;
    logic                   mispredict;
    logic                   push;
    logic [HIST_BITS-1:0]   head_idx;
    logic                   head_pred;
    logic [HIST_BITS-1:0]   head_ckpt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(INFLIGHT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    function automatic logic [CTR_BITS-1:0] sat_update(input logic [CTR_BITS-1:0] c, input logic up);
        if (up) return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        else    return (c == '0)      ? c : c - CTR_BITS'(1);
    endfunction

    // Index hash, prediction and resolve decisions; all read the pre-update table.
    always_comb begin
`ifdef GSHARE_XOR_EN
        idx        = spec_ghr ^ bus.pc_branch_addr[PC_LSB+HIST_BITS-1:PC_LSB];
`else
        idx        = spec_ghr;
`endif
        run        = (state == ST_RUN);
        fifo_full  = (count == CNT_W'(INFLIGHT_DEPTH));
        fifo_empty = (count == '0);
        head_idx   = fifo_idx[head];
        head_pred  = fifo_pred[head];
        head_ckpt  = fifo_ckpt[head];
        pred       = init_done_q & bus.branch_decode_sig & ctr_table[idx][CTR_BITS-1] & ~fifo_full;
        resolve    = run & bus.branch_mem_sig & ~fifo_empty;
        mispredict = resolve & (head_pred != bus.actual_branch_decision);
        // A decode alongside a mispredict is on the wrong path: shown but not tracked.
        push       = run & bus.branch_decode_sig & ~fifo_full & ~mispredict;
    end

    assign bus.prediction      = pred;
    assign bus.mispredict      = mispredict;
    assign bus.init_done       = init_done_q;
    assign bus.out_branch_addr = bus.pc_branch_addr + bus.offset;

    // Sweep FSM: walk every table entry once after reset, then run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            sweep_ptr   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    sweep_ptr <= sweep_ptr + HIST_BITS'(1);
                    if (sweep_ptr == '1) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_INIT;
            endcase
        end
    end

    // Counter table: weak-taken fill during the sweep, saturating training on resolve.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT)
                ctr_table[sweep_ptr] <= WEAK;
            else if (resolve)
                ctr_table[head_idx] <= sat_update(ctr_table[head_idx], bus.actual_branch_decision);
        end
    end

    // Queue payload; only the tail slot is written on a tracked decode.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[tail]  <= idx;
            fifo_pred[tail] <= pred;
            fifo_ckpt[tail] <= spec_ghr;
        end
    end

    // Speculative history and queue pointers; a mispredict repairs history and drops younger branches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spec_ghr <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (mispredict) begin
            spec_ghr <= {head_ckpt[HIST_BITS-2:0], bus.actual_branch_decision};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push)
                spec_ghr <= {spec_ghr[HIST_BITS-2:0], pred};
            case ({push, resolve})
                2'b10: begin
                    tail  <= ptr_inc(tail);
                    count <= count + CNT_W'(1);
                end
                2'b01: begin
                    head  <= ptr_inc(head);
                    count <= count - CNT_W'(1);
                end
                2'b11: begin
                    tail  <= ptr_inc(tail);
                    head  <= ptr_inc(head);
                end
                default: ;
            endcase
        end
    end
endmodule
